// File: rtl/hi_xcorr_sched.sv
// hi_xcorr_sched: mode scheduler and 64-sample window sequencer for the
// HF cross-correlator. Config words arrive MSB first on a serial side
// channel. Mode changes made while running take effect on a window
// boundary, followed by a programmable number of blanked windows.
//
// Ports:
//   ck_1356meg          13.56 MHz clock, rising edge
//   rst                 synchronous active-high reset
//   cfg_bit_en          strobe: sample cfg_sdata
//   cfg_sdata           serial config data, MSB first
//   cfg_frame           high while a config word is shifted in
//   corr_cnt            window sample counter 0..63
//   win_start           first sample of a reported window
//   win_valid           current window is reported
//   xcorr_is_848        subcarrier select
//   xcorr_quarter_freq  subcarrier select
//   snoop               snoop mode
//   running             sequencer not idle
//   cfg_err             pulse on a rejected word
//   wd_trip             pulse on a watchdog stop
//
// Optional watchdog: define HI_XCORR_SCHED_WATCHDOG_EN.
// Without it there is no counter and wd_trip is tied low.
module hi_xcorr_sched #(
`ifdef HI_XCORR_SCHED_WATCHDOG_EN
   parameter int WD_BITS   = 22,
`endif
   parameter int BLANK_RST = 2
) (
   input  logic       ck_1356meg,
   input  logic       rst,
   input  logic       cfg_bit_en,
   input  logic       cfg_sdata,
   input  logic       cfg_frame,
   output logic [5:0] corr_cnt,
   output logic       win_start,
   output logic       win_valid,
   output logic       xcorr_is_848,
   output logic       xcorr_quarter_freq,
   output logic       snoop,
   output logic       running,
   output logic       cfg_err,
   output logic       wd_trip
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PEND  = 2'd2;
   localparam logic [1:0] S_BLANK = 2'd3;

   // serial receiver
   logic [7:0] sh_q, sh_d;
   logic [3:0] bc_q, bc_d;
   logic       fr_q;

   // sequencer
   logic [1:0] st_q, st_d;
   logic [5:0] cnt_q, cnt_d;
   logic [3:0] brem_q, brem_d;
   logic [3:0] bcfg_q, bcfg_d;

   // mode bits are {snoop, is_848, quarter_freq}
   logic [2:0] mode_q, mode_d;
   logic [2:0] shad_q, shad_d;
   logic [2:0] new_mode;

   // registered flags
   logic       ws_q, ws_d;
   logic       wv_q, wv_d;
   logic       run_q, run_d;
   logic       err_q, err_d;

   // word decode
   logic       dec;
   logic       acc;
   logic [1:0] op;
   logic       mode_w;
   logic       bad_w;
   logic       blank_w;
   logic       start_w;
   logic       stop_w;
   logic       wrap;
   logic       wd_fire;
   logic       kill;

   assign dec      = fr_q & ~cfg_frame;
   assign acc      = dec & (bc_q == 4'd8);
   assign op       = sh_q[7:6];
   assign mode_w   = acc & (op == 2'b00) & (sh_q[1:0] != 2'b11);
   assign bad_w    = acc & (op == 2'b00) & (sh_q[1:0] == 2'b11);
   assign blank_w  = acc & (op == 2'b01);
   assign start_w  = acc & (op == 2'b10);
   assign stop_w   = acc & (op == 2'b11);
   assign wrap     = (cnt_q == 6'd63);
   assign kill     = stop_w | wd_fire;

   // 00 -> 424k, 01 -> 848k, 10 -> 212k
   assign new_mode = {sh_q[2], sh_q[1] | sh_q[0], sh_q[1]};

   always_comb begin
      sh_d   = sh_q;
      bc_d   = bc_q;
      st_d   = st_q;
      cnt_d  = (st_q == S_IDLE) ? 6'd0 : cnt_q + 6'd1;
      brem_d = brem_q;
      bcfg_d = bcfg_q;
      mode_d = mode_q;
      shad_d = shad_q;
      err_d  = (dec & ~acc) | bad_w;

      if (cfg_frame && cfg_bit_en) begin
         sh_d = {sh_q[6:0], cfg_sdata};
         if (bc_q != 4'd9) begin
            bc_d = bc_q + 4'd1;
         end
      end
      if (dec) begin
         bc_d = 4'd0;
      end

      // only later loads see a new blank count
      if (blank_w) begin
         bcfg_d = sh_q[3:0];
      end

      if (kill) begin
         st_d  = S_IDLE;
         cnt_d = 6'd0;
      end else begin
         unique case (st_q)
            S_IDLE: begin
               if (mode_w) begin
                  mode_d = new_mode;
               end else if (start_w) begin
                  brem_d = bcfg_q;
                  st_d   = (bcfg_q == 4'd0) ? S_RUN : S_BLANK;
               end
            end
            S_RUN: begin
               if (mode_w) begin
                  shad_d = new_mode;
                  st_d   = S_PEND;
               end
            end
            S_PEND: begin
               // a fresh word at the boundary defers to the next one
               if (mode_w) begin
                  shad_d = new_mode;
               end else if (wrap) begin
                  mode_d = shad_q;
                  brem_d = bcfg_q;
                  st_d   = (bcfg_q == 4'd0) ? S_RUN : S_BLANK;
               end
            end
            S_BLANK: begin
               if (mode_w) begin
                  shad_d = new_mode;
                  st_d   = S_PEND;
               end else if (wrap) begin
                  if (brem_q == 4'd1) begin
                     st_d = S_RUN;
                  end else begin
                     brem_d = brem_q - 4'd1;
                  end
               end
            end
            default: begin
               st_d = S_IDLE;
            end
         endcase
      end

      wv_d  = (st_d == S_RUN) || (st_d == S_PEND);
      ws_d  = wv_d && (cnt_d == 6'd0);
      run_d = (st_d != S_IDLE);
   end

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         sh_q   <= 8'd0;
         bc_q   <= 4'd0;
         fr_q   <= 1'b0;
         st_q   <= S_IDLE;
         cnt_q  <= 6'd0;
         brem_q <= 4'd0;
         bcfg_q <= 4'(BLANK_RST);
         mode_q <= 3'd0;
         shad_q <= 3'd0;
         ws_q   <= 1'b0;
         wv_q   <= 1'b0;
         run_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         bc_q   <= bc_d;
         fr_q   <= cfg_frame;
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         brem_q <= brem_d;
         bcfg_q <= bcfg_d;
         mode_q <= mode_d;
         shad_q <= shad_d;
         ws_q   <= ws_d;
         wv_q   <= wv_d;
         run_q  <= run_d;
         err_q  <= err_d;
      end
   end

`ifdef HI_XCORR_SCHED_WATCHDOG_EN
   logic [WD_BITS-1:0] wd_q, wd_d;
   logic               wdt_q;

   // any 8-bit word counts as ARM activity
   assign wd_fire = (st_q != S_IDLE) && (&wd_q);
   assign wd_d    = (acc || st_q == S_IDLE) ? '0 : wd_q + 1'b1;

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         wd_q  <= '0;
         wdt_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         wdt_q <= wd_fire;
      end
   end

   assign wd_trip = wdt_q;
`else
   assign wd_fire = 1'b0;
   assign wd_trip = 1'b0;
`endif

   assign corr_cnt           = cnt_q;
   assign win_start          = ws_q;
   assign win_valid          = wv_q;
   assign xcorr_is_848       = mode_q[1];
   assign xcorr_quarter_freq = mode_q[0];
   assign snoop              = mode_q[2];
   assign running            = run_q;
   assign cfg_err            = err_q;

endmodule
